// File: rtl/fsm_shift_pkg.sv
// rtl/fsm_shift_pkg.sv - shared state, mode and direction encodings for the shift sequencer
package fsm_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_SER = 2'b11;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-position shifter with selectable fill bit
module shift_step
    import fsm_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit
);

    logic w_fill;

    always_comb begin
        w_fill  = 1'b0;
        nxt     = cur;
        out_bit = 1'b0;
        if (dir == DIR_L) begin
            // Arithmetic left is identical to logical left.
            case (mode)
                MODE_ROT: w_fill = cur[WIDTH-1];
                MODE_SER: w_fill = ser_in;
                default:  w_fill = 1'b0;
            endcase
            nxt     = {cur[WIDTH-2:0], w_fill};
            out_bit = cur[WIDTH-1];
        end else begin
            case (mode)
                MODE_ARI: w_fill = cur[WIDTH-1];
                MODE_ROT: w_fill = cur[0];
                MODE_SER: w_fill = ser_in;
                default:  w_fill = 1'b0;
            endcase
            nxt     = {w_fill, cur[WIDTH-1:1]};
            out_bit = cur[0];
        end
    end

endmodule

// File: rtl/fsm_shift_seq.sv
// rtl/fsm_shift_seq.sv - load-then-shift sequencer: FSM, step counter and output registers
module fsm_shift_seq
    import fsm_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic             hold,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic             r_ser_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_mode;

    logic [CNT_W-1:0] w_amt_clamped;
    logic [WIDTH-1:0] w_nxt;
    logic             w_out_bit;

    assign w_amt_clamped = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur    (r_out),
        .dir    (r_dir),
        .mode   (r_mode),
        .ser_in (ser_in),
        .nxt    (w_nxt),
        .out_bit(w_out_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_amt_clamped == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!hold && (r_cnt == CNT_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Direction and mode are captured at load so the whole sequence is consistent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out     <= '0;
            r_ser_out <= 1'b0;
            r_cnt     <= '0;
            r_dir     <= DIR_R;
            r_mode    <= MODE_LOG;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_out  <= data;
                        r_dir  <= dir;
                        r_mode <= mode;
                        r_cnt  <= w_amt_clamped;
                    end
                end
                ST_SHIFT: begin
                    if (!hold) begin
                        r_out     <= w_nxt;
                        r_ser_out <= w_out_bit;
                        r_cnt     <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out     = r_out;
    assign ser_out = r_ser_out;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);

endmodule

// File: doc/fsm_shift_seq.md
Name: fsm_shift_seq

Overview:
Parametrised multi-mode shift sequencer. Loads a WIDTH-bit word on a start request, then shifts it one position per clock for a programmed number of steps. Supports direction, logical, arithmetic, rotate and serial-fill modes, a hold/stall input, a serial output tap and a one-cycle done pulse. Used as the general shift engine wherever a load-then-shift sequence is needed.

Parameters:
WIDTH, 8, data word width; legal range 2 or more.
CNT_W, $clog2(WIDTH+1), localparam (derived): width of the shift-amount field.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request to load and shift; sampled only in IDLE.
data  in  WIDTH  word loaded on an accepted start.
dir  in  1  0 = shift right (toward bit 0), 1 = shift left; latched on start.
mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-fill; latched on start.
amt  in  CNT_W  number of shift steps; latched on start.
hold  in  1  when 1 in SHIFT, freezes shift, count and ser_out.
ser_in  in  1  fill bit for serial-fill mode, sampled every shift cycle.
out  out  WIDTH  working register.
ser_out  out  1  registered copy of the bit shifted out on the last shift.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset: while rst is low, the block asynchronously forces out=0, ser_out=0, state=IDLE and the internal count to 0. busy and done are 0. Reset mid-shift aborts the operation with no done pulse.
- States: IDLE, SHIFT, DONE, in a 2-bit encoding. busy and done decode directly from the state register.
- IDLE: holds out. When start=1: out<=data; dir, mode and amt are latched. Internal count <= min(amt, WIDTH).
  - If the clamped count is 0, the next state is DONE.
  - Otherwise the next state is SHIFT.
- SHIFT: on each edge with hold=0:
  - out is updated by one step.
  - ser_out <= the departing bit: out[0] for right shifts, out[WIDTH-1] for left shifts.
  - count decrements by 1.
  - When count is 1 on that edge, the next state is DONE.
  - When hold=1, all registers hold.
- DONE: lasts exactly one cycle, then returns to IDLE. out and ser_out hold until the next accepted start.
- start is ignored in SHIFT and DONE, with no queuing. A start in the first IDLE cycle after DONE is accepted.
- Step rules, right direction:
  - logical: {0, out[W-1:1]}
  - arithmetic: {out[W-1], out[W-1:1]}
  - rotate: {out[0], out[W-1:1]}
  - serial-fill: {ser_in, out[W-1:1]}
- Step rules, left direction:
  - logical and arithmetic: {out[W-2:0], 0}
  - rotate: {out[W-2:0], out[W-1]}
  - serial-fill: {out[W-2:0], ser_in}
- Latency: start is accepted at edge E0. With N = clamped amt and no hold, shifts occur at E1..EN and done is high between EN and EN+1. busy is high from E0 to EN+1. For N=0, done is high between E0 and E1. Each hold cycle adds exactly one cycle.
- amt > WIDTH is clamped to WIDTH. A rotate by WIDTH returns the loaded word.

Decomposition:
- Package fsm_shift_pkg holds:
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE
  - mode constants: MODE_LOG, MODE_ARI, MODE_ROT, MODE_SER
  - direction constants: DIR_R, DIR_L
- Sub-module shift_step, parametrised by WIDTH: purely combinational one-position shifter.
  - Inputs: cur, dir, mode, ser_in.
  - Outputs: nxt, out_bit.
- The top level contains the FSM, the count register and the output registers.

Test Plan:
- WIDTH=8, data=0xB4, dir=0, mode=00, amt=3 -> out steps 0x5A, 0x2D, 0x16; ser_out 0, 0, 1; done pulses one cycle after E3; busy low at E4.
- Arithmetic right, data=0x90, amt=2 -> 0xC8, then 0xE4. Serial-fill right, data=0x00, ser_in=1, amt=3 -> final out 0xE0.
- Rotate left, data=0x81, amt=1 -> 0x03. Same data with amt=12 -> clamped to 8 shifts, final 0x81, done after E8.
- Left logical, data=0x0F, amt=4, hold=1 for 2 cycles after E2 -> final 0xF0, done delayed by exactly 2 cycles. start pulses during SHIFT have no effect.
- amt=0, data=0x5C -> out=0x5C at E0, done in the next cycle, ser_out unchanged. A back-to-back start in the IDLE cycle after DONE is accepted.
- rst driven low mid-SHIFT, between edges -> out=0, busy=0, done=0 immediately, with no done pulse. After rst release, a normal start works.
